// File: rtl/alu_pkg.sv
// Shared types for the parametrised multi-cycle ALU: operation encodings,
// controller states and the legal-op check.
package alu_pkg;

    typedef enum logic [2:0] {
        no_op  = 3'b000,
        add_op = 3'b001,
        and_op = 3'b010,
        xor_op = 3'b011,
        mul_op = 3'b100,
        sub_op = 3'b101
    } operation_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        MUL_WAIT = 2'd2,
        DONE     = 2'd3
    } state_t;

    // 3'b110 and 3'b111 have no operation behind them and complete with err.
    function automatic logic is_legal(input logic [2:0] op_code);
        case (op_code)
            no_op, add_op, and_op, xor_op, mul_op, sub_op: return 1'b1;
            default:                                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_mul_ctr.sv
// Loadable down-counter pacing the multiply wait; zero_next flags the cycle
// whose decrement brings the count to zero.
module alu_mul_ctr #(
    parameter int MUL_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic dec,
    output logic zero_next
);

    localparam int CW = $clog2(MUL_CYCLES + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_CYCLES - 1);

    logic [CW-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= LOAD_VAL;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero_next = (count_reg == CW'(1));

endmodule

// File: rtl/alu_param.sv
// Multi-cycle ALU with start/done handshake: single-cycle add/and/xor/sub,
// MUL_CYCLES-latency multiply, err pulse for undefined op codes.
module alu_param
    import alu_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int MUL_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 busy,
    output logic                 err
);

    state_t               state_reg, state_next;
    logic                 armed_reg;
    logic [2:0]           op_reg;
    logic [WIDTH-1:0]     a_reg, b_reg;
    logic [2*WIDTH-1:0]   result_reg, result_next;
    logic                 err_reg;

    logic                 accept;
    logic                 real_op;
    logic                 mul_last;
    logic [2:0]           cur_op;
    logic [WIDTH-1:0]     cur_a, cur_b;
    logic [WIDTH-1:0]     and_bits, xor_bits;
    logic [2*WIDTH-1:0]   ext_a, ext_b;

    assign accept  = (state_reg == IDLE) && start && armed_reg;
    assign real_op = (op != no_op);

    // Single-cycle ops finish on the accept edge, so they read the inputs
    // directly; the multiply finishes later and reads the captured copy.
    assign cur_op = accept ? op : op_reg;
    assign cur_a  = accept ? A  : a_reg;
    assign cur_b  = accept ? B  : b_reg;
    assign ext_a  = {{WIDTH{1'b0}}, cur_a};
    assign ext_b  = {{WIDTH{1'b0}}, cur_b};

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bitwise
            assign and_bits[gi] = cur_a[gi] & cur_b[gi];
            assign xor_bits[gi] = cur_a[gi] ^ cur_b[gi];
        end
    endgenerate

    always_comb begin
        result_next = '0;
        case (cur_op)
            add_op:  result_next = ext_a + ext_b;
            and_op:  result_next = {{WIDTH{1'b0}}, and_bits};
            xor_op:  result_next = {{WIDTH{1'b0}}, xor_bits};
            mul_op:  result_next = ext_a * ext_b;
            sub_op:  result_next = ext_a - ext_b;
            default: result_next = '0;
        endcase
    end

    alu_mul_ctr #(
        .MUL_CYCLES(MUL_CYCLES)
    ) u_mul_ctr (
        .clk       (clk),
        .reset     (reset),
        .load      (accept && (op == mul_op)),
        .dec       (state_reg == MUL_WAIT),
        .zero_next (mul_last)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (accept && real_op) begin
                    if ((op == mul_op) && (MUL_CYCLES > 1)) state_next = MUL_WAIT;
                    else                                    state_next = DONE;
                end
            end
            EXEC:     state_next = DONE;
            MUL_WAIT: if (mul_last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            armed_reg  <= 1'b1;
            op_reg     <= '0;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            err_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            // no_op leaves the handshake armed so a held start re-accepts.
            if (!start)                armed_reg <= 1'b1;
            else if (accept && real_op) armed_reg <= 1'b0;
            if (accept) begin
                op_reg <= op;
                a_reg  <= A;
                b_reg  <= B;
            end
            if (state_next == DONE) begin
                result_reg <= result_next;
                err_reg    <= !is_legal(cur_op);
            end else begin
                err_reg    <= 1'b0;
            end
        end
    end

    assign done   = (state_reg == DONE);
    assign busy   = (state_reg != IDLE);
    assign err    = err_reg;
    assign result = result_reg;

endmodule

// File: tb/tb_alu_param.sv
// Scoreboard bench for alu_param: two instances (MUL_CYCLES=3 and 1), expected
// results queued at drive time and retired by a done monitor.
module tb_alu_param;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [2:0]  op;
    logic [7:0]  a, b;
    logic        done0, busy0, err0;
    logic        done1, busy1, err1;
    logic [15:0] result0, result1;

    always #5 clk = ~clk;

    alu_param #(.WIDTH(8), .MUL_CYCLES(3)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .op(op), .A(a), .B(b),
        .done(done0), .result(result0), .busy(busy0), .err(err0)
    );

    alu_param #(.WIDTH(8), .MUL_CYCLES(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .A(a), .B(b),
        .done(done1), .result(result1), .busy(busy1), .err(err1)
    );

    typedef struct {
        logic [15:0] res;
        logic        err;
        int          due;
        int          sel;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cycle = 0;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        total++;
        if (got !== expv) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [15:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        case (o)
            add_op:  return 16'(x) + 16'(y);
            and_op:  return {8'h00, x & y};
            xor_op:  return {8'h00, x ^ y};
            mul_op:  return 16'(x) * 16'(y);
            sub_op:  return 16'(x) - 16'(y);
            default: return 16'h0000;
        endcase
    endfunction

    // Done monitor: retires the oldest expectation on each done pulse.
    exp_t        mon_e;
    logic [15:0] mon_res;
    logic        mon_err;
    always @(negedge clk) begin
        if (!reset && (done0 || done1)) begin
            if (sb.size() == 0) begin
                check("spurious_done", {30'b0, done1, done0}, 32'd0);
            end else begin
                mon_e   = sb.pop_front();
                mon_res = (mon_e.sel != 0) ? result1 : result0;
                mon_err = (mon_e.sel != 0) ? err1 : err0;
                check("done_dut", {30'b0, done1, done0}, (mon_e.sel != 0) ? 32'd2 : 32'd1);
                check("result", {16'b0, mon_res}, {16'b0, mon_e.res});
                check("err", {31'b0, mon_err}, {31'b0, mon_e.err});
                check("latency", cycle, mon_e.due);
                $display("txn dut%0d result=%h err=%0d cycle=%0d", mon_e.sel, mon_res, mon_err, cycle);
            end
        end
    end

    // Raise start with a command and hold it until the monitor has seen done.
    task automatic issue(input int sel, input logic [2:0] o, input logic [7:0] av,
                         input logic [7:0] bv, input int lat, input logic [15:0] er,
                         input logic ee);
        exp_t t;
        int   busy_n;
        int   ok;
        @(negedge clk);
        op = o;
        a  = av;
        b  = bv;
        if (sel != 0) start1 = 1'b1;
        else          start0 = 1'b1;
        t.res = er;
        t.err = ee;
        t.due = cycle + lat;
        t.sel = sel;
        sb.push_back(t);
        busy_n = 0;
        ok     = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (((sel != 0) ? busy1 : busy0) == 1'b1) busy_n++;
            if (i == 0) begin
                a  = 8'($urandom);
                b  = 8'($urandom);
                op = 3'($urandom);
            end
            if (sb.size() == 0) begin
                ok = 1;
                break;
            end
        end
        check("done_seen", ok, 32'd1);
        if (ok == 0) sb.delete();
        check("busy_cycles", busy_n, lat);
    endtask

    task automatic release_start();
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ro;
        logic [7:0] ra, rb;
        reset  = 1'b1;
        start0 = 1'b0;
        start1 = 1'b0;
        op     = no_op;
        a      = '0;
        b      = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_done", {31'b0, done0}, 32'd0);
        check("rst_busy", {31'b0, busy0}, 32'd0);
        check("rst_err", {31'b0, err0}, 32'd0);
        check("rst_result", {16'b0, result0}, 32'd0);
        check("rst_result1", {16'b0, result1}, 32'd0);
        reset = 1'b0;

        issue(0, add_op, 8'hFF, 8'h01, 1, 16'h0100, 1'b0);
        release_start();
        issue(0, mul_op, 8'hFF, 8'hFF, 3, 16'hFE01, 1'b0);
        release_start();
        issue(1, mul_op, 8'hFF, 8'hFF, 1, 16'hFE01, 1'b0);
        release_start();
        issue(0, sub_op, 8'h03, 8'h05, 1, 16'hFFFE, 1'b0);
        release_start();
        issue(0, and_op, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0);
        release_start();
        issue(0, xor_op, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0);
        release_start();

        issue(0, 3'b110, 8'h12, 8'h34, 1, 16'h0000, 1'b1);
        release_start();
        issue(0, add_op, 8'h10, 8'h20, 1, 16'h0030, 1'b0);
        release_start();
        issue(0, 3'b111, 8'h55, 8'h66, 1, 16'h0000, 1'b1);
        release_start();

        // start stays high after done: no second accept until a low cycle.
        issue(0, xor_op, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("held_busy", {31'b0, busy0}, 32'd0);
        end
        check("held_result", {16'b0, result0}, 32'h00CC);
        release_start();
        issue(0, xor_op, 8'hAA, 8'h0F, 1, 16'h00A5, 1'b0);
        release_start();

        // no_op held high re-accepts silently and keeps the handshake armed.
        @(negedge clk);
        op     = no_op;
        start0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            check("noop_busy", {31'b0, busy0}, 32'd0);
        end
        issue(0, add_op, 8'h01, 8'h02, 1, 16'h0003, 1'b0);
        release_start();

        // Reset one cycle after a mul accept abandons it.
        @(negedge clk);
        op     = mul_op;
        a      = 8'h07;
        b      = 8'h09;
        start0 = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset  = 1'b0;
        start0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("abort_busy", {31'b0, busy0}, 32'd0);
        end
        check("abort_result", {16'b0, result0}, 32'd0);
        issue(0, add_op, 8'hFF, 8'h01, 1, 16'h0100, 1'b0);
        release_start();

        for (int i = 0; i < 6; i++) begin
            case ($urandom_range(4, 0))
                0:       ro = add_op;
                1:       ro = and_op;
                2:       ro = xor_op;
                3:       ro = mul_op;
                default: ro = sub_op;
            endcase
            ra = 8'($urandom);
            rb = 8'($urandom);
            issue(0, ro, ra, rb, (ro == mul_op) ? 3 : 1, model(ro, ra, rb), 1'b0);
            release_start();
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_param.md
Name: alu_param

Overview:
Parametrised multi-cycle ALU DUT. Successor to the fixed 8-bit start/done ALU exercised by the team's ALU bench.
- Operand width and multiply latency are parameters.
- Adds a subtract op, an illegal-op error flag and a busy indicator.
- Keeps the start-held-until-done handshake, so the existing driver/monitor protocol works unchanged.

Parameters:
WIDTH, 8, operand width in bits (>=2)
MUL_CYCLES, 3, cycles from command accept to done for mul (>=1)

Ports:
clk  in  1  single clock, all logic on posedge
reset  in  1  synchronous, active-high reset
start  in  1  command request, held high by master until done seen
op  in  3  operation encoding (see package)
A  in  WIDTH  operand A, unsigned
B  in  WIDTH  operand B, unsigned
done  out  1  one-cycle pulse, result valid
result  out  2*WIDTH  operation result, held until next accept
busy  out  1  high from accept until the cycle done is asserted, inclusive
err  out  1  one-cycle pulse coincident with done for illegal op

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is reset.
- Reset values: done=0, err=0, busy=0, result=0, state=IDLE, armed=1.
- Reset wins over every other event, including mid-operation: any in-flight op is abandoned and no done is issued.
- Armed flag: set on any posedge with start=0; cleared on accept. A new command needs a low period on start, which prevents re-accept while the master still holds start after done.
- Accept: posedge with state=IDLE, start=1, armed=1. Captures op, A, B; later changes on these inputs are ignored.
- States: IDLE, EXEC, MUL_WAIT, DONE.
  - no_op (000): accepted with no done, no busy, no state change. armed stays 1, so start held high with no_op re-accepts each cycle, matching the monitor's per-cycle no_op collection.
  - add/and/xor/sub/illegal: IDLE -> DONE. done=1 on the posedge after accept (latency 1).
  - mul: IDLE -> MUL_WAIT with counter = MUL_CYCLES-1. Counter decrements each cycle; at 0 -> DONE. done=1 exactly MUL_CYCLES cycles after accept. With MUL_CYCLES=1, mul behaves like a single-cycle op.
  - DONE: done=1 for one cycle, then IDLE. A command cannot be accepted in the DONE cycle itself.
- Arithmetic (all unsigned, zero-extended to 2*WIDTH):
  - add: A+B, carry kept in bit WIDTH.
  - and, xor: bitwise, upper WIDTH bits 0.
  - mul: full 2*WIDTH product.
  - sub (101): (A-B) mod 2^(2*WIDTH), i.e. sign-extended two's complement.
  - illegal (110, 111): result=0, err=1 with done.
- start dropped after accept: the op still completes and done still pulses.
- result changes only on the done cycle or reset.

Decomposition:
- Package alu_pkg: operation_t enum (no_op=000, add_op=001, and_op=010, xor_op=011, mul_op=100, sub_op=101), state enum, function is_legal(op).
- Bench-only rst_op stays in tb_pkg and is never decoded by RTL.
- Sub-module alu_mul_ctr: loadable down-counter sized $clog2(MUL_CYCLES+1), with a zero flag. Product is computed from the captured operands.

Test Plan (WIDTH=8, MUL_CYCLES=3 unless noted):
- Reset asserted 2 cycles, released -> done=0, busy=0, result=0. Then add A=8'hFF B=8'h01 -> done 1 cycle after accept, result=16'h0100.
- mul A=8'hFF B=8'hFF, start held -> done exactly 3 cycles after accept, busy high 3 cycles, result=16'hFE01. Repeat with MUL_CYCLES=1 -> latency 1.
- sub A=8'h03 B=8'h05 -> result=16'hFFFE. and A=8'hF0 B=8'h3C -> 16'h0030. xor A=8'hF0 B=8'h3C -> 16'h00CC.
- op=3'b110 -> done and err pulse together, result=0. Next legal add clears err (err=0 on its done).
- start held high after done with no low cycle -> no second accept. Drop start 1 cycle, raise with xor -> accepted.
- Reset asserted 1 cycle after mul accept -> no done ever, state IDLE, result=0. Fresh add then completes normally.
